// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream offer (instr, pc, operands), flush, and the held decoded result.
// master drives instructions toward the stage; slave is the issue stage itself.
interface alu_issue_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_rs1_val;
    logic [WIDTH-1:0] in_rs2_val;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_alusel;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [4:0]       out_rd;
    logic             out_rd_we;
    logic             out_illegal;
    logic [WIDTH-1:0] out_pc;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_alusel, out_a, out_b, out_rd, out_rd_we,
               out_illegal, out_pc
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_alusel, out_a, out_b, out_rd, out_rd_we,
               out_illegal, out_pc
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I issue stage: decodes ALU select and operands into a one-deep register.
// Latency 1 cycle from capture to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds all outputs.
module alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]       alusel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       rd;
        logic             rd_we;
        logic             illegal;
        logic [WIDTH-1:0] pc;
    } issue_t;

    issue_t           d;
    issue_t           q;
    logic             q_vld;
    logic             capture;
    logic [6:0]       opcode;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic             legal;
    logic             is_shift;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] b_raw;

    // alt selects sub/sra; OP-IMM passes 0 for funct3 000 since addi has no subi.
    function automatic logic [3:0] f3_to_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        case (f3)
            3'd0:    sel = alt ? 4'd1 : 4'd0;
            3'd1:    sel = 4'd2;
            3'd2:    sel = 4'd3;
            3'd3:    sel = 4'd4;
            3'd4:    sel = 4'd5;
            3'd5:    sel = alt ? 4'd7 : 4'd6;
            3'd6:    sel = 4'd8;
            default: sel = 4'd9;
        endcase
        return sel;
    endfunction

    always_comb begin
        opcode   = bus.in_instr[6:0];
        funct3   = bus.in_instr[14:12];
        funct7   = bus.in_instr[31:25];
        imm_i    = WIDTH'($signed(bus.in_instr[31:20]));
        imm_s    = WIDTH'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
        imm_u    = WIDTH'($signed({bus.in_instr[31:12], 12'b0}));
        legal    = 1'b1;
        b_raw    = '0;
        d        = '0;
        d.rd     = bus.in_instr[11:7];
        d.pc     = bus.in_pc;

        case (opcode)
            OPC_OP: begin
                legal    = (funct7 == F7_BASE) ||
                           ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
                d.alusel = f3_to_sel(funct3, funct7[5]);
                d.a      = bus.in_rs1_val;
                b_raw    = bus.in_rs2_val;
                d.rd_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'd1)
                    legal = (funct7 == F7_BASE);
                else if (funct3 == 3'd5)
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                d.alusel = f3_to_sel(funct3, (funct3 == 3'd5) && funct7[5]);
                d.a      = bus.in_rs1_val;
                b_raw    = imm_i;
                d.rd_we  = 1'b1;
            end
            OPC_LUI: begin
                b_raw   = imm_u;
                d.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                d.a     = bus.in_pc;
                b_raw   = imm_u;
                d.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                d.a     = bus.in_rs1_val;
                b_raw   = imm_i;
                d.rd_we = 1'b1;
            end
            OPC_STORE: begin
                d.a   = bus.in_rs1_val;
                b_raw = imm_s;
            end
            default: legal = 1'b0;
        endcase

        // The ALU shifts by the whole of B, so only the 5-bit shamt may reach it.
        is_shift = (d.alusel == 4'd2) || (d.alusel == 4'd6) || (d.alusel == 4'd7);
        d.b      = is_shift ? WIDTH'(b_raw[4:0]) : b_raw;

        if (!legal) begin
            d.alusel  = '0;
            d.a       = '0;
            d.b       = '0;
            d.rd_we   = 1'b0;
            d.illegal = 1'b1;
        end
        if (d.rd == 5'd0)
            d.rd_we = 1'b0;
    end

    assign bus.in_ready = !q_vld || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_vld <= 1'b0;
            q     <= '0;
        end else if (bus.flush) begin
            q_vld <= 1'b0;
        end else if (capture) begin
            q_vld <= 1'b1;
            q     <= d;
        end else if (bus.out_ready) begin
            q_vld <= 1'b0;
        end
    end

    assign bus.out_valid   = q_vld;
    assign bus.out_alusel  = q.alusel;
    assign bus.out_a       = q.a;
    assign bus.out_b       = q.b;
    assign bus.out_rd      = q.rd;
    assign bus.out_rd_we   = q.rd_we;
    assign bus.out_illegal = q.illegal;
    assign bus.out_pc      = q.pc;
endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-to-execute issue stage that produces the ALU operation select and both operands for the RV32I datapath. It accepts one fetched instruction, its PC and both register-file read values, decodes the ALU operation (`ALUSel` encoding 0–9), muxes and immediate-extends the operands, and holds the result in a one-deep pipeline register. A valid/ready handshake on each side lets the execute stage stall the issue stage, and a synchronous flush squashes the held instruction.

## Interface

- WIDTH, 32, datapath width; the instruction is always 32 bits.

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  squash the held instruction and drop any capture this cycle
- in_valid  input  1  upstream offers an instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- in_pc  input  WIDTH  instruction PC
- in_rs1_val  input  WIDTH  register-file value for instr[19:15]
- in_rs2_val  input  WIDTH  register-file value for instr[24:20]
- out_valid  output  1  held instruction valid
- out_ready  input  1  execute stage consumes this cycle
- out_alusel  output  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and
- out_a  output  WIDTH  ALU operand A
- out_b  output  WIDTH  ALU operand B
- out_rd  output  5  destination register, instr[11:7]
- out_rd_we  output  1  writeback enable
- out_illegal  output  1  instruction not decodable by this stage
- out_pc  output  WIDTH  PC of the held instruction

## Operation

- Decoding is combinational from in_instr. Results are registered on capture, where capture = in_valid && in_ready && !flush.
- OP (0110011). funct3 000: add if funct7=0000000, sub if 0100000. Other funct3 values map to: 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (funct7=0000000) or sra (0100000), 110 or, 111 and. a=rs1, b=rs2, rd_we=1.
- OP funct7 legality: any funct7 other than 0000000 is illegal, except 0100000 with funct3 000 or 101.
- OP-IMM (0010011). Same funct3 map, with funct3 000 always add. a=rs1, b=sign-extended instr[31:20], rd_we=1.
- OP-IMM shift legality: funct3 001 requires instr[31:25]=0000000. funct3 101 requires 0000000 (srl) or 0100000 (sra); anything else is illegal.
- Shift operand rule: for every shift (sll/srl/sra, reg or imm), b = zero-extended b[4:0]. The ALU shifts by the full operand B.
- LUI (0110111): add, a=0, b={instr[31:12],12'b0}, rd_we=1.
- AUIPC (0010111): add, a=pc, b=U-immediate, rd_we=1.
- LOAD (0000011): add, a=rs1, b=I-immediate, rd_we=1.
- STORE (0100011): add, a=rs1, b=S-immediate {instr[31:25],instr[11:7]} sign-extended, rd_we=0.
- Any other opcode, or an illegal funct: illegal=1, alusel=0, a=0, b=0, rd_we=0. The instruction still handshakes normally.
- rd_we is forced to 0 when rd=0.
- Immediates are sign-extended from bit 31 to WIDTH.

## Timing

- Latency is 1 cycle: an instruction captured at edge N is presented with out_valid=1 after edge N.
- in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
- Register update at each rising edge, highest priority first:
  - !rst_n: out_valid=0 and all data outputs cleared to 0.
  - flush: out_valid=0; data registers hold their values.
  - capture: out_valid=1 and all data registers load.
  - out_ready: out_valid=0.
  - otherwise: hold.
- Consume and capture in the same cycle give back-to-back throughput of 1 instruction per cycle.
- Stall: while out_valid && !out_ready, all outputs are stable and in_ready=0.
- When out_valid=0, data outputs hold their last value and the consumer must ignore them.
- Reset or flush mid-stall discards the held instruction. It is never presented again.

## Test plan

- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, all data outputs 0. Release -> first capture visible one cycle later.
- R-type: instr 0x40208033 (sub x0? no: rd=x0) and 0x402081B3 (sub x3,x1,x2), rs1=10, rs2=3 -> first: alusel=1, rd_we=0. Second: alusel=1, a=10, b=3, rd=3, rd_we=1.
- Shift and immediate: srai x5,x6,4 (0x40435293), rs1=0xF0000000 -> alusel=7, b=4. sll with rs2=0x00000123 -> b=0x3. addi with imm=-1 -> b=0xFFFFFFFF.
- Upper/mem: lui x1,0x12345 -> a=0, b=0x12345000, alusel=0. auipc at pc=0x100 -> a=0x100. sw x2,8(x1) -> b=8, rd_we=0.
- Illegal: opcode 1100011 and add with funct7=0000001 -> illegal=1, alusel=0, a=b=0, rd_we=0, handshake completes.
- Handshake: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 continuous -> 1 instruction per cycle. Flush during the stall -> out_valid=0 next cycle and the stalled instruction is never seen.
